// File: rtl/xy_resource_ni.sv
// Resource-side network interface of an XY mesh node: packs PE requests into
// packets for the switch, and buffers address-checked packets from the switch for the PE.
module xy_resource_ni #(
  parameter int X_CORD          = 0,
  parameter int Y_CORD          = 0,
  parameter int PCKT_XADDR_W    = 4,
  parameter int PCKT_YADDR_W    = 4,
  parameter int PCKT_DATA_W     = 8,
  parameter int PCKT_W          = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W,
  parameter int RX_FIFO_DEPTH_W = 2,
  parameter int CNT_W           = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pe_tx_vld_i,
  output logic                    pe_tx_rdy_o,
  input  logic [PCKT_XADDR_W-1:0] pe_tx_x_i,
  input  logic [PCKT_YADDR_W-1:0] pe_tx_y_i,
  input  logic [PCKT_DATA_W-1:0]  pe_tx_data_i,
  output logic                    sw_wr_en_o,
  output logic [PCKT_W-1:0]       sw_pckt_o,
  input  logic                    sw_full_i,
  input  logic                    sw_wr_en_i,
  input  logic [PCKT_W-1:0]       sw_pckt_i,
  output logic                    rx_full_o,
  output logic                    rx_overflow_o,
  output logic                    pe_rx_vld_o,
  input  logic                    pe_rx_rdy_i,
  output logic [PCKT_DATA_W-1:0]  pe_rx_data_o,
  output logic [CNT_W-1:0]        tx_cnt_o,
  output logic [CNT_W-1:0]        rx_cnt_o,
  output logic [CNT_W-1:0]        drop_cnt_o,
  output logic [CNT_W-1:0]        misroute_cnt_o
);

  localparam int DEPTH = 1 << RX_FIFO_DEPTH_W;
  localparam int CW    = RX_FIFO_DEPTH_W + 1;

  typedef enum logic {IDLE, SEND} tx_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------- Tx path ----------------
  tx_state_e         state, state_nxt;
  logic [PCKT_W-1:0] hold, hold_nxt;
  logic              accept;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    pe_tx_rdy_o = (state == IDLE) | ~sw_full_i;
    sw_wr_en_o  = (state == SEND) & ~sw_full_i;
    sw_pckt_o   = (state == SEND) ? hold : '0;
    accept      = pe_tx_vld_i & pe_tx_rdy_o;
    state_nxt   = state;
    hold_nxt    = hold;
    // An accept while writing reloads the hold register and keeps SEND for full throughput.
    if (accept) begin
      hold_nxt  = {pe_tx_x_i, pe_tx_y_i, pe_tx_data_i};
      state_nxt = SEND;
    end else if (sw_wr_en_o) begin
      state_nxt = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      hold     <= '0;
      tx_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      if (sw_wr_en_o) tx_cnt_o <= sat_inc(tx_cnt_o);
    end
  end

  // ---------------- Rx path ----------------
  logic [PCKT_DATA_W-1:0]     mem [DEPTH];
  logic [RX_FIFO_DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]              count, count_nxt;
  logic                       addr_match, push, pop;

  assign addr_match = (sw_pckt_i[PCKT_W-1 -: PCKT_XADDR_W] == PCKT_XADDR_W'(X_CORD)) &&
                      (sw_pckt_i[PCKT_DATA_W+PCKT_YADDR_W-1 -: PCKT_YADDR_W] == PCKT_YADDR_W'(Y_CORD));
  // Full comes from the current count, so a same-cycle pop never frees room for a push.
  assign push         = sw_wr_en_i & addr_match & ~rx_full_o;
  assign pop          = pe_rx_vld_o & pe_rx_rdy_i;
  assign pe_rx_vld_o  = (count != '0);
  assign pe_rx_data_o = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rx_full_o      <= 1'b0;
      rx_overflow_o  <= 1'b0;
      rx_cnt_o       <= '0;
      drop_cnt_o     <= '0;
      misroute_cnt_o <= '0;
    end else begin
      count         <= count_nxt;
      rx_full_o     <= (count_nxt == CW'(DEPTH));
      rx_overflow_o <= sw_wr_en_i & addr_match & rx_full_o;
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_cnt_o <= sat_inc(rx_cnt_o);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (sw_wr_en_i & ~addr_match) misroute_cnt_o <= sat_inc(misroute_cnt_o);
      if (sw_wr_en_i & addr_match & rx_full_o) drop_cnt_o <= sat_inc(drop_cnt_o);
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= sw_pckt_i[PCKT_DATA_W-1:0];
  end

endmodule
